// File: rtl/mbus_rf_responder_if.sv
// MBUS member-side RX/TX bus between the bus controller and a layer responder.
// The slave modport is the responder's view; master is the controller's view.
interface mbus_rf_responder_if;
    logic [31:0] rx_addr;
    logic [31:0] rx_data;
    logic        rx_req;
    logic        rx_ack;
    logic        rx_pend;
    logic        rx_broadcast;
    logic        rx_fail;
    logic [31:0] tx_addr;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        tx_ack;
    logic        tx_pend;
    logic        tx_priority;
    logic        tx_succ;
    logic        tx_fail;
    logic        tx_resp_ack;

    modport slave (
        input  rx_addr, rx_data, rx_req, rx_pend, rx_broadcast, rx_fail,
        input  tx_ack, tx_succ, tx_fail,
        output rx_ack,
        output tx_addr, tx_data, tx_req, tx_pend, tx_priority, tx_resp_ack
    );

    modport master (
        output rx_addr, rx_data, rx_req, rx_pend, rx_broadcast, rx_fail,
        output tx_ack, tx_succ, tx_fail,
        input  rx_ack,
        input  tx_addr, tx_data, tx_req, tx_pend, tx_priority, tx_resp_ack
    );
endinterface

// File: rtl/mbus_rf_responder.sv
// MBUS layer responder: RF-write messages load a NUM_REGS x 24-bit register
// file, RF-read messages stream register contents back over the TX interface.
module mbus_rf_responder #(
    parameter int         NUM_REGS      = 8,
    parameter logic [3:0] RF_WRITE_FUID = 4'h0,
    parameter logic [3:0] RF_READ_FUID  = 4'h1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    mbus_rf_responder_if.slave       io_bus,
    output logic [NUM_REGS*24-1:0]   o_rf_data,
    output logic [NUM_REGS-1:0]      o_rf_load,
    output logic                     o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_HOLD,
        S_TX_REQ,
        S_TX_WAITACK,
        S_TX_WAITRESP,
        S_TX_RESPACK
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [23:0]   r_rf [NUM_REGS];
    logic [NUM_REGS-1:0] r_rf_load;
    logic          r_rd_pending;
    logic [7:0]    r_start;
    logic [7:0]    r_cnt_m1;
    logic [7:0]    r_reply_addr;
    logic [7:0]    r_dest;
    logic [7:0]    r_idx;
    logic [31:0]   r_tx_addr;
    logic [31:0]   r_tx_data;
    logic          r_tx_pend;

    logic          w_rx_accept;
    logic [3:0]    w_fuid;
    logic [7:0]    w_wr_idx;
    logic          w_load_word;
    logic [7:0]    w_word_idx;
    logic [8:0]    w_rd_idx;
    logic [23:0]   w_rd_val;

    assign w_fuid      = io_bus.rx_addr[3:0];
    assign w_wr_idx    = io_bus.rx_data[31:24];
    assign w_rx_accept = (r_state == S_IDLE) && io_bus.rx_req && !io_bus.rx_broadcast;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_load_word marks the edge on which TX_REQ rises for a reply word.
    always_comb begin
        w_next      = r_state;
        w_load_word = 1'b0;
        w_word_idx  = r_idx + 8'd1;
        case (r_state)
            S_IDLE: begin
                if (io_bus.rx_req) w_next = S_RX_HOLD;
            end
            S_RX_HOLD: begin
                if (!io_bus.rx_req) begin
                    if (r_rd_pending && !io_bus.rx_fail) begin
                        w_next      = S_TX_REQ;
                        w_load_word = 1'b1;
                        w_word_idx  = 8'd0;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_TX_REQ: begin
                if (io_bus.tx_fail)     w_next = S_TX_RESPACK;
                else if (io_bus.tx_ack) w_next = S_TX_WAITACK;
            end
            S_TX_WAITACK: begin
                if (io_bus.tx_fail) begin
                    w_next = S_TX_RESPACK;
                end else if (!io_bus.tx_ack) begin
                    if (r_idx == r_cnt_m1) begin
                        w_next = S_TX_WAITRESP;
                    end else begin
                        w_next      = S_TX_REQ;
                        w_load_word = 1'b1;
                    end
                end
            end
            S_TX_WAITRESP: begin
                if (io_bus.tx_succ || io_bus.tx_fail) w_next = S_TX_RESPACK;
            end
            S_TX_RESPACK: begin
                if (!io_bus.tx_succ && !io_bus.tx_fail) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Indices past the last register read as zero rather than wrapping.
    always_comb begin
        w_rd_idx = {1'b0, r_start} + {1'b0, w_word_idx};
        w_rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_idx == 9'(k)) w_rd_val = r_rf[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) r_rf[k] <= '0;
            r_rf_load    <= '0;
            r_rd_pending <= 1'b0;
            r_start      <= '0;
            r_cnt_m1     <= '0;
            r_reply_addr <= '0;
            r_dest       <= '0;
            r_idx        <= '0;
            r_tx_addr    <= '0;
            r_tx_data    <= '0;
            r_tx_pend    <= 1'b0;
        end else begin
            r_rf_load <= '0;
            if (w_rx_accept && w_fuid == RF_WRITE_FUID) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (w_wr_idx == 8'(k)) begin
                        r_rf[k]      <= io_bus.rx_data[23:0];
                        r_rf_load[k] <= 1'b1;
                    end
                end
            end else if (w_rx_accept && w_fuid == RF_READ_FUID) begin
                r_rd_pending <= 1'b1;
                r_start      <= io_bus.rx_data[31:24];
                r_cnt_m1     <= io_bus.rx_data[23:16];
                r_reply_addr <= io_bus.rx_data[15:8];
                r_dest       <= io_bus.rx_data[7:0];
            end
            if (r_state == S_RX_HOLD && io_bus.rx_fail) r_rd_pending <= 1'b0;
            if (w_load_word) begin
                r_rd_pending <= 1'b0;
                r_idx        <= w_word_idx;
                r_tx_addr    <= {24'h0, r_reply_addr};
                r_tx_data    <= {r_dest + w_word_idx, w_rd_val};
                r_tx_pend    <= (w_word_idx != r_cnt_m1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_rf_data[24*g +: 24] = r_rf[g];
    end

    assign io_bus.rx_ack      = (r_state == S_RX_HOLD);
    assign io_bus.tx_req      = (r_state == S_TX_REQ);
    assign io_bus.tx_resp_ack = (r_state == S_TX_RESPACK);
    assign io_bus.tx_priority = 1'b0;
    assign io_bus.tx_addr     = r_tx_addr;
    assign io_bus.tx_data     = r_tx_data;
    assign io_bus.tx_pend     = r_tx_pend;
    assign o_rf_load          = r_rf_load;
    assign o_busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_mbus_rf_responder.sv
// Directed bench for mbus_rf_responder acting as the MBUS controller side.
module tb_mbus_rf_responder;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mbus_rf_responder_if bus ();
    logic [NR*24-1:0] rf_data;
    logic [NR-1:0]    rf_load;
    logic             busy;

    mbus_rf_responder #(.NUM_REGS(NR)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .io_bus    (bus),
        .o_rf_data (rf_data),
        .o_rf_load (rf_load),
        .o_busy    (busy)
    );

    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_rf [NR];
    logic        mon_en = 1'b0;
    int          ack_hits = 0;

    // Counts RX acknowledges seen while a reply is in flight.
    always @(negedge clk) if (mon_en && bus.rx_ack) ack_hits++;

    function automatic logic [NR*24-1:0] pack_rf();
        logic [NR*24-1:0] r;
        for (int k = 0; k < NR; k++) r[24*k +: 24] = exp_rf[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_word(input logic [31:0] a, input logic [31:0] d, input logic p, input logic b,
                           output logic [NR-1:0] lor, output int lcyc, output bit ok);
        int n;
        ok = 1'b1; lor = '0; lcyc = 0;
        bus.rx_addr = a; bus.rx_data = d; bus.rx_pend = p; bus.rx_broadcast = b; bus.rx_req = 1'b1;
        n = 0;
        do begin
            tick(); lor |= rf_load; if (rf_load != '0) lcyc++; n++;
        end while (!bus.rx_ack && n < 50);
        if (!bus.rx_ack) ok = 1'b0;
        bus.rx_req = 1'b0;
        n = 0;
        do begin
            tick(); lor |= rf_load; if (rf_load != '0) lcyc++; n++;
        end while (bus.rx_ack && n < 50);
        if (bus.rx_ack) ok = 1'b0;
        bus.rx_broadcast = 1'b0; bus.rx_pend = 1'b0;
    endtask

    task automatic tx_word(output logic [31:0] a, output logic [31:0] d, output logic p, output bit ok);
        int n;
        ok = 1'b1; a = '0; d = '0; p = 1'b0;
        n = 0;
        while (!bus.tx_req && n < 50) begin tick(); n++; end
        if (!bus.tx_req) begin ok = 1'b0; return; end
        a = bus.tx_addr; d = bus.tx_data; p = bus.tx_pend;
        bus.tx_ack = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.tx_req && n < 50);
        if (bus.tx_req) ok = 1'b0;
        bus.tx_ack = 1'b0;
        tick();
    endtask

    task automatic tx_resp(input logic fail, output bit ok);
        int n;
        ok = 1'b1;
        if (fail) bus.tx_fail = 1'b1; else bus.tx_succ = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.tx_resp_ack && n < 50);
        if (!bus.tx_resp_ack) ok = 1'b0;
        bus.tx_fail = 1'b0; bus.tx_succ = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.tx_resp_ack && n < 50);
        if (bus.tx_resp_ack) ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_addr = '0; bus.rx_data = '0; bus.rx_req = 1'b0; bus.rx_pend = 1'b0;
        bus.rx_broadcast = 1'b0; bus.rx_fail = 1'b0;
        bus.tx_ack = 1'b0; bus.tx_succ = 1'b0; bus.tx_fail = 1'b0;
        for (int k = 0; k < NR; k++) exp_rf[k] = 24'h0;
        rst = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        total++; if (bus.rx_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_ack got=%b exp=0", bus.rx_ack); end
        total++; if (bus.tx_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_req got=%b exp=0", bus.tx_req); end
        total++; if (bus.tx_pend !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_pend got=%b exp=0", bus.tx_pend); end
        total++; if (bus.tx_resp_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_ack got=%b exp=0", bus.tx_resp_ack); end
        total++; if (bus.tx_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_tx_addr got=%h exp=0", bus.tx_addr); end
        total++; if (bus.tx_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
        total++; if (rf_load !== 8'h00) begin bad++; $display("[TB] FAIL reset_rf_load got=%h exp=00", rf_load); end
        total++; if (rf_data !== '0) begin bad++; $display("[TB] FAIL reset_rf_data got=%h exp=0", rf_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        logic [NR-1:0] lor; int lcyc; bit ok;
        rx_word(32'h0000_0000, 32'h02ABCDEF, 1'b0, 1'b0, lor, lcyc, ok);
        exp_rf[2] = 24'hABCDEF;
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL wr1_handshake got=%b exp=1", ok); end
        total++; if (lor !== 8'b0000_0100) begin bad++; $display("[TB] FAIL wr1_load got=%b exp=00000100", lor); end
        total++; if (lcyc !== 1) begin bad++; $display("[TB] FAIL wr1_load_cycles got=%0d exp=1", lcyc); end
        total++; if (rf_data !== pack_rf()) begin bad++; $display("[TB] FAIL wr1_rf got=%h exp=%h", rf_data, pack_rf()); end
    endtask

    task automatic test_multi_write();
        logic [31:0]   dat [4]  = '{32'h00000011, 32'h01000022, 32'h07000077, 32'h09000099};
        logic          pnd [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [NR-1:0] msk [4]  = '{8'h01, 8'h02, 8'h80, 8'h00};
        logic [NR-1:0] lor; int lcyc; bit ok;
        for (int i = 0; i < 4; i++) begin
            rx_word(32'h0000_0000, dat[i], pnd[i], 1'b0, lor, lcyc, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL mw_handshake[%0d] got=%b exp=1", i, ok); end
            total++; if (lor !== msk[i]) begin bad++; $display("[TB] FAIL mw_load[%0d] got=%b exp=%b", i, lor, msk[i]); end
        end
        exp_rf[0] = 24'h000011; exp_rf[1] = 24'h000022; exp_rf[7] = 24'h000077;
        total++; if (rf_data !== pack_rf()) begin bad++; $display("[TB] FAIL mw_rf got=%h exp=%h", rf_data, pack_rf()); end
    endtask

    task automatic test_read_two();
        logic [NR-1:0] lor; int lcyc; bit ok;
        logic [31:0] a, d; logic p;
        rx_word(32'h0000_0001, 32'h00011410, 1'b0, 1'b0, lor, lcyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rd2_rx got=%b exp=1", ok); end
        total++; if (bus.tx_priority !== 1'b0) begin bad++; $display("[TB] FAIL rd2_priority got=%b exp=0", bus.tx_priority); end
        tx_word(a, d, p, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rd2_w0_hs got=%b exp=1", ok); end
        total++; if (a !== 32'h00000014) begin bad++; $display("[TB] FAIL rd2_w0_addr got=%h exp=00000014", a); end
        total++; if (d !== 32'h10000011) begin bad++; $display("[TB] FAIL rd2_w0_data got=%h exp=10000011", d); end
        total++; if (p !== 1'b1) begin bad++; $display("[TB] FAIL rd2_w0_pend got=%b exp=1", p); end
        tx_word(a, d, p, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rd2_w1_hs got=%b exp=1", ok); end
        total++; if (d !== 32'h11000022) begin bad++; $display("[TB] FAIL rd2_w1_data got=%h exp=11000022", d); end
        total++; if (p !== 1'b0) begin bad++; $display("[TB] FAIL rd2_w1_pend got=%b exp=0", p); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rd2_waitresp_busy got=%b exp=1", busy); end
        tx_resp(1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rd2_resp_hs got=%b exp=1", ok); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rd2_idle got=%b exp=0", busy); end
    endtask

    task automatic test_read_oob();
        logic [31:0] ed [4] = '{32'h00000000, 32'h01000077, 32'h02000000, 32'h03000000};
        logic        ep [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [NR-1:0] lor; int lcyc; bit ok;
        logic [31:0] a, d; logic p;
        rx_word(32'h0000_0001, 32'h06031400, 1'b0, 1'b0, lor, lcyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL oob_rx got=%b exp=1", ok); end
        for (int i = 0; i < 4; i++) begin
            tx_word(a, d, p, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL oob_hs[%0d] got=%b exp=1", i, ok); end
            total++; if (a !== 32'h00000014) begin bad++; $display("[TB] FAIL oob_addr[%0d] got=%h exp=00000014", i, a); end
            total++; if (d !== ed[i]) begin bad++; $display("[TB] FAIL oob_data[%0d] got=%h exp=%h", i, d, ed[i]); end
            total++; if (p !== ep[i]) begin bad++; $display("[TB] FAIL oob_pend[%0d] got=%b exp=%b", i, p, ep[i]); end
        end
        tx_resp(1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL oob_resp got=%b exp=1", ok); end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] lor; int lcyc; bit ok; int n;
        logic [31:0] a, d; logic p;
        rx_word(32'h0000_0001, 32'h02001402, 1'b0, 1'b0, lor, lcyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_rx got=%b exp=1", ok); end
        bus.rx_addr = 32'h0000_0000; bus.rx_data = 32'h03333333; bus.rx_req = 1'b1;
        ack_hits = 0; mon_en = 1'b1;
        tx_word(a, d, p, ok);
        total++; if (d !== 32'h02ABCDEF) begin bad++; $display("[TB] FAIL b2b_data got=%h exp=02abcdef", d); end
        total++; if (p !== 1'b0) begin bad++; $display("[TB] FAIL b2b_pend got=%b exp=0", p); end
        tx_resp(1'b0, ok);
        mon_en = 1'b0;
        total++; if (ack_hits !== 0) begin bad++; $display("[TB] FAIL b2b_ack_during_reply got=%0d exp=0", ack_hits); end
        n = 0;
        while (!bus.rx_ack && n < 20) begin tick(); n++; end
        total++; if (bus.rx_ack !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pending_ack got=%b exp=1", bus.rx_ack); end
        bus.rx_req = 1'b0;
        n = 0;
        while (bus.rx_ack && n < 20) begin tick(); n++; end
        exp_rf[3] = 24'h333333;
        total++; if (rf_data !== pack_rf()) begin bad++; $display("[TB] FAIL b2b_rf got=%h exp=%h", rf_data, pack_rf()); end
    endtask

    task automatic test_tx_fail();
        logic [NR-1:0] lor; int lcyc; bit ok; int n; int req_seen;
        logic [31:0] a, d; logic p;
        rx_word(32'h0000_0001, 32'h00021420, 1'b0, 1'b0, lor, lcyc, ok);
        tx_word(a, d, p, ok);
        total++; if (d !== 32'h20000011) begin bad++; $display("[TB] FAIL txf_w0 got=%h exp=20000011", d); end
        n = 0;
        while (!bus.tx_req && n < 20) begin tick(); n++; end
        total++; if (bus.tx_data !== 32'h21000022) begin bad++; $display("[TB] FAIL txf_w1 got=%h exp=21000022", bus.tx_data); end
        bus.tx_fail = 1'b1;
        tick();
        total++; if (bus.tx_req !== 1'b0) begin bad++; $display("[TB] FAIL txf_req_drop got=%b exp=0", bus.tx_req); end
        total++; if (bus.tx_resp_ack !== 1'b1) begin bad++; $display("[TB] FAIL txf_resp_ack got=%b exp=1", bus.tx_resp_ack); end
        bus.tx_fail = 1'b0;
        n = 0;
        while (bus.tx_resp_ack && n < 20) begin tick(); n++; end
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus.tx_req) req_seen++; end
        total++; if (req_seen !== 0) begin bad++; $display("[TB] FAIL txf_no_more_req got=%0d exp=0", req_seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL txf_idle got=%b exp=0", busy); end
    endtask

    task automatic test_ignored();
        logic [NR-1:0] lor; int lcyc; bit ok;
        rx_word(32'h0000_0000, 32'h04444444, 1'b0, 1'b1, lor, lcyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL bcast_hs got=%b exp=1", ok); end
        total++; if (lor !== 8'h00) begin bad++; $display("[TB] FAIL bcast_load got=%b exp=00000000", lor); end
        rx_word(32'h0000_0005, 32'h05555555, 1'b0, 1'b0, lor, lcyc, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL fu5_hs got=%b exp=1", ok); end
        total++; if (lor !== 8'h00) begin bad++; $display("[TB] FAIL fu5_load got=%b exp=00000000", lor); end
        total++; if (rf_data !== pack_rf()) begin bad++; $display("[TB] FAIL ign_rf got=%h exp=%h", rf_data, pack_rf()); end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] lor; int lcyc; bit ok; int n;
        rx_word(32'h0000_0001, 32'h00001400, 1'b0, 1'b0, lor, lcyc, ok);
        n = 0;
        while (!bus.tx_req && n < 20) begin tick(); n++; end
        bus.tx_ack = 1'b1;
        tick();
        total++; if (busy !== 1'b1 || bus.tx_req !== 1'b0) begin bad++; $display("[TB] FAIL rm_waitack got=%b%b exp=10", busy, bus.tx_req); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy got=%b exp=0", busy); end
        total++; if (rf_data !== '0) begin bad++; $display("[TB] FAIL rm_rf got=%h exp=0", rf_data); end
        total++; if (bus.tx_data !== 32'h0 || bus.tx_addr !== 32'h0) begin bad++; $display("[TB] FAIL rm_tx got=%h/%h exp=0/0", bus.tx_addr, bus.tx_data); end
        total++; if (bus.rx_ack !== 1'b0 || bus.tx_resp_ack !== 1'b0) begin bad++; $display("[TB] FAIL rm_acks got=%b%b exp=00", bus.rx_ack, bus.tx_resp_ack); end
        bus.tx_ack = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) exp_rf[k] = 24'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_write();
        test_read_two();
        test_read_oob();
        test_back_to_back();
        test_tx_fail();
        test_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbus_rf_responder.md
Name: mbus_rf_responder

Overview:
- Member-layer responder: consumes messages delivered by the MBUS bus controller's RX interface. These are the requests a host issues via the controller's TX interface: RF load and RF read.
- Holds a NUM_REGS x 24-bit register file written by RF-write messages.
- Answers RF-read messages by sending RF contents back through the controller's TX interface.
- Sits between mbus_ctrl_wrapper (member side) and layer logic.

Parameters:
NUM_REGS, 8, number of 24-bit registers (1..256)
RF_WRITE_FUID, 4'h0, functional ID for RF write
RF_READ_FUID, 4'h1, functional ID for RF read

Ports:
CLK  input  1  system clock, shared with the bus controller RX/TX interface
RESET  input  1  asynchronous, active-high reset
RX_ADDR  input  32  received address; [3:0] is the FU ID
RX_DATA  input  32  received data word
RX_REQ  input  1  receive request (four-phase)
RX_ACK  output  1  receive acknowledge
RX_PEND  input  1  more words follow in this message
RX_BROADCAST  input  1  message is broadcast
RX_FAIL  input  1  receive failure indication
TX_ADDR  output  32  reply address
TX_DATA  output  32  reply data
TX_REQ  output  1  transmit request (four-phase)
TX_ACK  input  1  transmit acknowledge
TX_PEND  output  1  more reply words follow
TX_PRIORITY  output  1  tied 0
TX_SUCC  input  1  reply transfer succeeded
TX_FAIL  input  1  reply transfer failed
TX_RESP_ACK  output  1  acknowledge of TX_SUCC/TX_FAIL
RF_DATA  output  NUM_REGS*24  flattened RF; reg i at [24i+23:24i]
RF_LOAD  output  NUM_REGS  one-cycle pulse per written register
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous: all RF registers are 24'h0. RX_ACK, TX_REQ, TX_PEND, TX_RESP_ACK and BUSY are 0. TX_ADDR, TX_DATA and RF_LOAD are 0. State is IDLE.
- States: IDLE, RX_HOLD, TX_REQ, TX_WAITACK, TX_WAITRESP, TX_RESPACK.
- IDLE, RX_REQ sampled 1: on the next edge, RX_ACK goes to 1 and the state moves to RX_HOLD. The word is decoded on that same edge:
  - Broadcast, or FU ID not write/read: word is discarded.
  - FU ID = RF_WRITE_FUID: index = RX_DATA[31:24], value = RX_DATA[23:0].
    - If index < NUM_REGS, the register is written on this edge and RF_LOAD[index] pulses for exactly 1 cycle.
    - If index >= NUM_REGS, nothing is written and there is no pulse.
    - Each word of a multi-word message (RX_PEND=1) is an independent write.
  - FU ID = RF_READ_FUID: latch the read command.
    - start = RX_DATA[31:24]
    - count = RX_DATA[23:16] + 1, giving 1..256
    - reply short address = RX_DATA[15:8]
    - destination offset = RX_DATA[7:0]
- RX_HOLD: RX_ACK stays 1 while RX_REQ=1. When RX_REQ is sampled 0, RX_ACK drops on the next edge. Then:
  - If a read is latched, go to TX_REQ.
  - Otherwise go to IDLE.
- Backpressure: RX_REQ is not acknowledged outside IDLE. A request arriving during a reply waits.
- RX_FAIL=1 in RX_HOLD: a latched read is cancelled. Writes already performed stand.
- Reply word i, for i = 0..count-1:
  - TX_ADDR = {24'h0, reply address}.
  - TX_DATA = {(dest+i) mod 256, RF[start+i]}.
  - If start+i >= NUM_REGS, the data field is 24'h0. Register indices do not wrap.
  - TX_PEND = 1 for every word except the last.
- TX_REQ state: drive TX_REQ=1 with TX_ADDR, TX_DATA and TX_PEND stable.
  - When TX_ACK is sampled 1, drop TX_REQ and go to TX_WAITACK.
- TX_WAITACK: wait for TX_ACK to be sampled 0.
  - If more words remain, advance i and go to TX_REQ.
  - Otherwise go to TX_WAITRESP.
- TX_WAITRESP: on TX_SUCC or TX_FAIL sampled 1, set TX_RESP_ACK=1 and go to TX_RESPACK.
- TX_RESPACK: when both TX_SUCC and TX_FAIL are sampled 0, drop TX_RESP_ACK and go to IDLE.
- TX_FAIL=1 while in TX_REQ or TX_WAITACK: abort the remaining words and handle it as in TX_WAITRESP. TX_REQ drops.
- RF reads in a reply are sampled at the cycle TX_REQ rises for that word.
- RESET asserted mid-operation: immediate return to reset values, including clearing the RF.

Test Plan:
- Reset, then RX write FU 0x0 with data 32'h02ABCDEF -> RX_ACK handshake completes. RF[2]=24'hABCDEF. RF_LOAD=8'b00000100 for 1 cycle. All other registers stay 0.
- Multi-word write of 0x00000011, 0x01000022, 0x07000077 (RX_PEND=1,1,0), then write index 0x09 -> RF[0]=0x11, RF[1]=0x22, RF[7]=0x77. Index 9 is ignored with no RF_LOAD pulse.
- After RF[0..1] are loaded, RX read FU 0x1 with data 32'h00011410 -> two TX words on address 32'h00000014:
  - 32'h10000011 with TX_PEND=1.
  - 32'h11000022 with TX_PEND=0.
  - Controller TX_SUCC then gets TX_RESP_ACK, then return to IDLE.
- Read with data 32'h06031400 (start 6, count 4) -> words 32'h00000000 | RF[6], 32'h01000077, 32'h02000000, 32'h03000000.
- Second RX_REQ raised during a reply -> RX_ACK stays 0 until IDLE, then that request is serviced. Also: TX_FAIL during word 1 of 3 -> no further TX_REQ, TX_RESP_ACK handshake, IDLE.
- Broadcast write and FU 0x5 write -> RX_ACK handshake completes. RF unchanged, no RF_LOAD pulse. RESET asserted during TX_WAITACK -> outputs at reset values immediately.
